// File: rtl/mac_tile_dbuf.sv
// Systolic-array processing element: weight-stationary or output-stationary MAC with a
// double-buffered kernel register and a south-bound accumulator drain chain.
module mac_tile_dbuf #(
    parameter int bw         = 4,
    parameter int psum_bw    = 16,
    parameter bit act_signed = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [bw-1:0]      in_w,
    input  logic [3:0]         inst_w,
    output logic [bw-1:0]      out_e,
    output logic [3:0]         inst_e,
    input  logic [psum_bw-1:0] in_n,
    input  logic               in_n_valid,
    output logic [psum_bw-1:0] out_s,
    output logic               out_s_valid,
    output logic               err
);

    logic [bw-1:0]      bank0, bank1;
    logic               active;
    logic               load_ready;
    logic               mode_q;
    logic [psum_bw-1:0] acc;

    logic [bw-1:0]      w_active;
    logic [psum_bw-1:0] prod_ws, prod_os, weight_fwd;
    logic               mode_change;

    function automatic logic [psum_bw-1:0] prod(input logic [bw-1:0] a, input logic [bw-1:0] w);
        logic signed [psum_bw-1:0] ae, we;
        ae = {{(psum_bw-bw){act_signed & a[bw-1]}}, a};
        we = {{(psum_bw-bw){w[bw-1]}}, w};
        return ae * we;
    endfunction

    always_comb begin
        w_active    = active ? bank1 : bank0;
        prod_ws     = prod(in_w, w_active);
        prod_os     = prod(in_w, in_n[bw-1:0]);
        weight_fwd  = {{(psum_bw-bw){1'b0}}, in_n[bw-1:0]};
        mode_change = (mode != mode_q);
    end

    // Load handshake: inst_w[0] is the load valid, load_ready the accept. A token is consumed
    // only when both are high; an unaccepted token travels east to the next tile in the row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_e       <= '0;
            inst_e      <= '0;
            out_s       <= '0;
            out_s_valid <= 1'b0;
            err         <= 1'b0;
            bank0       <= '0;
            bank1       <= '0;
            active      <= 1'b0;
            load_ready  <= 1'b1;
            mode_q      <= 1'b0;
            acc         <= '0;
        end else begin
            if (inst_w[0] || inst_w[1]) out_e <= in_w;
            inst_e <= {inst_w[3:1], inst_w[0] & ~load_ready};

            // The load targets the pre-swap shadow bank, so load+swap makes it active at once.
            if (inst_w[0] && load_ready) begin
                if (active) bank0 <= in_w;
                else        bank1 <= in_w;
            end
            if (inst_w[2]) begin
                active     <= ~active;
                load_ready <= 1'b1;
            end else if (inst_w[0]) begin
                load_ready <= 1'b0;
            end

            mode_q <= mode;
            if (!mode) begin
                if (inst_w[1]) out_s <= in_n + prod_ws;
                out_s_valid <= 1'b0;
            end else if (inst_w[3]) begin
                out_s       <= acc + (inst_w[1] ? prod_os : '0);
                out_s_valid <= 1'b1;
                acc         <= '0;
                if (in_n_valid) err <= 1'b1;
            end else if (in_n_valid) begin
                out_s       <= in_n;
                out_s_valid <= 1'b1;
            end else begin
                out_s       <= weight_fwd;
                out_s_valid <= 1'b0;
                if (inst_w[1]) acc <= acc + prod_os;
            end

            // A mode switch discards the stationary sum and any pending drain beat.
            if (mode_change) begin
                acc         <= '0;
                out_s_valid <= 1'b0;
            end
        end
    end

endmodule
